// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat carrying a control field and a payload field.
// A beat transfers on a clock edge where valid and ready are both 1; the master holds
// valid, ctrl and data stable while valid=1 and ready=0.
interface pipe_stage_skid_if #(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 69
);
   logic              valid;
   logic              ready;
   logic [CTRL_W-1:0] ctrl;
   logic [DATA_W-1:0] data;

   modport master (output valid, output ctrl, output data, input ready);
   modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline stage: main register plus one-entry skid, full-rate valid/ready,
// synchronous flush with bubble insertion and a saturating backpressure counter.
module pipe_stage_skid #(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 69,
   parameter int CNT_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   pipe_stage_skid_if.slave   up,
   pipe_stage_skid_if.master  dn,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              main_valid_q, main_valid_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic              skid_valid_q, skid_valid_d;
   logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_ready_q, in_ready_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic accept;
   logic emit;

   assign accept = up.valid & in_ready_q;
   assign emit   = main_valid_q & dn.ready;

   always_comb begin
      state_d      = state_q;
      main_valid_d = main_valid_q;
      main_ctrl_d  = main_ctrl_q;
      main_data_d  = main_data_q;
      skid_valid_d = skid_valid_q;
      skid_ctrl_d  = skid_ctrl_q;
      skid_data_d  = skid_data_q;
      in_ready_d   = in_ready_q;
      stall_cnt_d  = stall_cnt_q;

      if (main_valid_q && !dn.ready && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);

      // Flush wins over any transfer; payload registers deliberately keep their contents.
      if (flush) begin
         state_d      = EMPTY;
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_ctrl_d  = '0;
         skid_ctrl_d  = '0;
         in_ready_d   = 1'b1;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_valid_d = 1'b1;
                  main_ctrl_d  = up.ctrl;
                  main_data_d  = up.data;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (accept && emit) begin
                  main_ctrl_d = up.ctrl;
                  main_data_d = up.data;
               end else if (accept) begin
                  skid_valid_d = 1'b1;
                  skid_ctrl_d  = up.ctrl;
                  skid_data_d  = up.data;
                  in_ready_d   = 1'b0;
                  state_d      = FULL;
               end else if (emit) begin
                  main_valid_d = 1'b0;
                  state_d      = EMPTY;
               end
            end
            FULL: begin
               if (emit && skid_valid_q) begin
                  main_ctrl_d  = skid_ctrl_q;
                  main_data_d  = skid_data_q;
                  skid_valid_d = 1'b0;
                  in_ready_d   = 1'b1;
                  state_d      = ONE;
               end
            end
            default: begin
               state_d      = EMPTY;
               main_valid_d = 1'b0;
               skid_valid_d = 1'b0;
               in_ready_d   = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= EMPTY;
         main_valid_q <= 1'b0;
         main_ctrl_q  <= '0;
         main_data_q  <= '0;
         skid_valid_q <= 1'b0;
         skid_ctrl_q  <= '0;
         skid_data_q  <= '0;
         in_ready_q   <= 1'b1;
         stall_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         main_valid_q <= main_valid_d;
         main_ctrl_q  <= main_ctrl_d;
         main_data_q  <= main_data_d;
         skid_valid_q <= skid_valid_d;
         skid_ctrl_q  <= skid_ctrl_d;
         skid_data_q  <= skid_data_d;
         in_ready_q   <= in_ready_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   // Ctrl is masked so a bubble can never assert a write enable downstream.
   assign up.ready  = in_ready_q;
   assign dn.valid  = main_valid_q;
   assign dn.ctrl   = main_valid_q ? main_ctrl_q : '0;
   assign dn.data   = main_data_q;
   assign stall_cnt = stall_cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: a vector table for streaming, backpressure and
// flush, plus hand-written sequences for counter saturation and asynchronous reset.
module tb_pipe_stage_skid;

   localparam int CTRL_W = 2;
   localparam int DATA_W = 69;
   localparam int NV     = 21;

   logic clk = 1'b0;
   logic reset;
   logic flush_a;
   logic flush_b;
   logic [15:0] stall_a;
   logic [3:0]  stall_b;
   logic [1:0]  state_a;
   logic [1:0]  state_b;

   int checks = 0;
   int errors = 0;

   pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) a_up ();
   pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) a_dn ();
   pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) b_up ();
   pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) b_dn ();

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(16)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush_a),
      .up        (a_up),
      .dn        (a_dn),
      .stall_cnt (stall_a),
      .state_dbg (state_a)
   );

   pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(4)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush_b),
      .up        (b_up),
      .dn        (b_dn),
      .stall_cnt (stall_b),
      .state_dbg (state_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              iv;
      logic [CTRL_W-1:0] ic;
      logic [DATA_W-1:0] id;
      logic              ordy;
      logic              fl;
      logic              e_ov;
      logic [CTRL_W-1:0] e_oc;
      logic [DATA_W-1:0] e_od;
      logic              e_ir;
      logic [15:0]       e_st;
      logic [1:0]        e_state;
   } vec_t;

   vec_t vecs [NV];

   function automatic vec_t mk(input logic iv, input logic [1:0] ic, input logic [7:0] id,
                               input logic ordy, input logic fl, input logic e_ov,
                               input logic [1:0] e_oc, input logic [7:0] e_od,
                               input logic e_ir, input logic [15:0] e_st,
                               input logic [1:0] e_state);
      vec_t v;
      v.iv = iv; v.ic = ic; v.id = DATA_W'(id); v.ordy = ordy; v.fl = fl;
      v.e_ov = e_ov; v.e_oc = e_oc; v.e_od = DATA_W'(e_od); v.e_ir = e_ir;
      v.e_st = e_st; v.e_state = e_state;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input logic e_ov, input logic [1:0] e_oc,
                          input logic [DATA_W-1:0] e_od, input logic e_ir,
                          input logic [15:0] e_st, input logic [1:0] e_state);
      check({tag, ".out_valid"}, 128'(a_dn.valid), 128'(e_ov));
      check({tag, ".out_ctrl"},  128'(a_dn.ctrl),  128'(e_oc));
      check({tag, ".out_data"},  128'(a_dn.data),  128'(e_od));
      check({tag, ".in_ready"},  128'(a_up.ready), 128'(e_ir));
      check({tag, ".stall_cnt"}, 128'(stall_a),    128'(e_st));
      check({tag, ".state"},     128'(state_a),    128'(e_state));
   endtask

   initial begin
      // stream at full rate
      vecs[0]  = mk(1, 2'd1, 8'h11, 1, 0,  1, 2'd1, 8'h11, 1, 16'd0, 2'd1);
      vecs[1]  = mk(1, 2'd2, 8'h22, 1, 0,  1, 2'd2, 8'h22, 1, 16'd0, 2'd1);
      vecs[2]  = mk(1, 2'd3, 8'h33, 1, 0,  1, 2'd3, 8'h33, 1, 16'd0, 2'd1);
      vecs[3]  = mk(0, 2'd0, 8'h00, 1, 0,  0, 2'd0, 8'h33, 1, 16'd0, 2'd0);
      // backpressure: A into main, B into skid, C held upstream
      vecs[4]  = mk(1, 2'd1, 8'h0A, 0, 0,  1, 2'd1, 8'h0A, 1, 16'd0, 2'd1);
      vecs[5]  = mk(1, 2'd2, 8'h0B, 0, 0,  1, 2'd1, 8'h0A, 0, 16'd1, 2'd2);
      vecs[6]  = mk(1, 2'd3, 8'h0C, 0, 0,  1, 2'd1, 8'h0A, 0, 16'd2, 2'd2);
      vecs[7]  = mk(1, 2'd3, 8'h0C, 0, 0,  1, 2'd1, 8'h0A, 0, 16'd3, 2'd2);
      vecs[8]  = mk(1, 2'd3, 8'h0C, 1, 0,  1, 2'd2, 8'h0B, 1, 16'd3, 2'd1);
      vecs[9]  = mk(1, 2'd3, 8'h0C, 1, 0,  1, 2'd3, 8'h0C, 1, 16'd3, 2'd1);
      vecs[10] = mk(0, 2'd0, 8'h00, 1, 0,  0, 2'd0, 8'h0C, 1, 16'd3, 2'd0);
      // accept and emit together in ONE
      vecs[11] = mk(1, 2'd1, 8'h44, 1, 0,  1, 2'd1, 8'h44, 1, 16'd3, 2'd1);
      vecs[12] = mk(1, 2'd2, 8'h55, 1, 0,  1, 2'd2, 8'h55, 1, 16'd3, 2'd1);
      vecs[13] = mk(0, 2'd0, 8'h00, 1, 0,  0, 2'd0, 8'h55, 1, 16'd3, 2'd0);
      // flush while FULL with an incoming ctrl=3 beat
      vecs[14] = mk(1, 2'd1, 8'h66, 0, 0,  1, 2'd1, 8'h66, 1, 16'd3, 2'd1);
      vecs[15] = mk(1, 2'd2, 8'h77, 0, 0,  1, 2'd1, 8'h66, 0, 16'd4, 2'd2);
      vecs[16] = mk(1, 2'd3, 8'h88, 0, 1,  0, 2'd0, 8'h66, 1, 16'd5, 2'd0);
      vecs[17] = mk(0, 2'd0, 8'h00, 1, 0,  0, 2'd0, 8'h66, 1, 16'd5, 2'd0);
      // flush in ONE discards the beat accepted in the same cycle
      vecs[18] = mk(1, 2'd1, 8'h99, 0, 0,  1, 2'd1, 8'h99, 1, 16'd5, 2'd1);
      vecs[19] = mk(1, 2'd3, 8'hAA, 0, 1,  0, 2'd0, 8'h99, 1, 16'd6, 2'd0);
      vecs[20] = mk(0, 2'd0, 8'h00, 1, 0,  0, 2'd0, 8'h99, 1, 16'd6, 2'd0);

      reset = 1'b1;
      flush_a = 1'b0; flush_b = 1'b0;
      a_up.valid = 1'b0; a_up.ctrl = '0; a_up.data = '0; a_dn.ready = 1'b0;
      b_up.valid = 1'b0; b_up.ctrl = '0; b_up.data = '0; b_dn.ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_a("reset", 1'b0, 2'd0, '0, 1'b1, 16'd0, 2'd0);

      for (int i = 0; i < NV; i++) begin
         a_up.valid = vecs[i].iv;
         a_up.ctrl  = vecs[i].ic;
         a_up.data  = vecs[i].id;
         a_dn.ready = vecs[i].ordy;
         flush_a    = vecs[i].fl;
         tick();
         check_a($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_oc, vecs[i].e_od,
                 vecs[i].e_ir, vecs[i].e_st, vecs[i].e_state);
      end
      flush_a = 1'b0;
      a_up.valid = 1'b0;

      // 4-bit stall counter held off by 20 stalled cycles
      b_up.valid = 1'b1; b_up.ctrl = 2'd1; b_up.data = DATA_W'(8'h5A); b_dn.ready = 1'b0;
      tick();
      b_up.valid = 1'b0;
      check("sat.first_valid", 128'(b_dn.valid), 128'(1'b1));
      check("sat.start_cnt", 128'(stall_b), 128'(4'd0));
      for (int k = 1; k <= 20; k++) begin
         tick();
         check($sformatf("sat.cnt%0d", k), 128'(stall_b), 128'((k > 15) ? 15 : k));
      end
      check("sat.still_valid", 128'(b_dn.valid), 128'(1'b1));
      b_dn.ready = 1'b1;
      tick();
      check("sat.drained", 128'(b_dn.valid), 128'(1'b0));
      check("sat.hold", 128'(stall_b), 128'(4'd15));
      check("sat.data", 128'(b_dn.data), 128'(DATA_W'(8'h5A)));

      // asynchronous reset while FULL
      a_dn.ready = 1'b0;
      a_up.valid = 1'b1; a_up.ctrl = 2'd3; a_up.data = DATA_W'(8'hC1);
      tick();
      a_up.ctrl = 2'd2; a_up.data = DATA_W'(8'hC2);
      tick();
      a_up.valid = 1'b0;
      check_a("pre_rst", 1'b1, 2'd3, DATA_W'(8'hC1), 1'b0, 16'd7, 2'd2);
      #1;
      reset = 1'b1;
      #1;
      check_a("async_rst", 1'b0, 2'd0, '0, 1'b1, 16'd0, 2'd0);
      @(negedge clk);
      reset = 1'b0;
      a_dn.ready = 1'b1;
      tick();
      check_a("post_rst", 1'b0, 2'd0, '0, 1'b1, 16'd0, 2'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
